bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 114 +++++++++++
 tb/tb_bus_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with grant hold, watchdog release and one-cycle turnaround.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority (master 1).
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic m1_req,
    input  logic m2_req,
    input  logic bus_s_ack,
    output logic m1_grant,
    output logic m2_grant,
    output logic msel,
    output logic arb_timeout,
    output logic arb_busy
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT1  = 2'd1,
        S_GRANT2  = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            msel_q, msel_d;
    logic            timeout_q, timeout_d;
    logic            m1_grant_q, m2_grant_q, busy_q;
    logic            owner_req;
    logic            wd_expire;
    logic            pick_m2;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // last_owner_q: 0 = master 1 held the bus last, 1 = master 2.
    logic last_owner_q;

    assign pick_m2 = m2_req && (!m1_req || !last_owner_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= 1'b1;
        end else if (state_q == S_IDLE && (m1_req || m2_req)) begin
            last_owner_q <= pick_m2;
        end
    end
`else
    assign pick_m2 = m2_req && !m1_req;
`endif

    assign owner_req = (state_q == S_GRANT2) ? m2_req : m1_req;
    assign wd_expire = (wd_cnt_q == WD_LAST) && !bus_s_ack;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d   = state_q;
        wd_cnt_d  = wd_cnt_q;
        msel_d    = msel_q;
        timeout_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (m1_req || m2_req) begin
                    state_d  = pick_m2 ? S_GRANT2 : S_GRANT1;
                    msel_d   = pick_m2;
                    wd_cnt_d = '0;
                end
            end
            S_GRANT1, S_GRANT2: begin
                // Ack and request drop both win over the watchdog, so no pulse accompanies them.
                if (bus_s_ack || !owner_req) begin
                    state_d = S_RELEASE;
                end else if (wd_expire) begin
                    state_d   = S_RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wd_cnt_q   <= '0;
            msel_q     <= 1'b0;
            timeout_q  <= 1'b0;
            m1_grant_q <= 1'b0;
            m2_grant_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            wd_cnt_q   <= wd_cnt_d;
            msel_q     <= msel_d;
            timeout_q  <= timeout_d;
            m1_grant_q <= (state_d == S_GRANT1);
            m2_grant_q <= (state_d == S_GRANT2);
            busy_q     <= (state_d == S_GRANT1) || (state_d == S_GRANT2);
        end
    end

    assign m1_grant    = m1_grant_q;
    assign m2_grant    = m2_grant_q;
    assign msel        = msel_q;
    assign arb_timeout = timeout_q;
    assign arb_busy    = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus hand sequences for watchdog, ack-at-expiry and reset.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic m1_req, m2_req, bus_s_ack;
    logic m1_grant, m2_grant, msel, arb_timeout, arb_busy;
    logic b_m1_grant, b_m2_grant, b_msel, b_arb_timeout, b_arb_busy;

    int checks   = 0;
    int failures = 0;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .m1_req(m1_req), .m2_req(m2_req), .bus_s_ack(bus_s_ack),
        .m1_grant(m1_grant), .m2_grant(m2_grant), .msel(msel),
        .arb_timeout(arb_timeout), .arb_busy(arb_busy)
    );

    bus_arbiter dut64 (
        .clk(clk), .rst_n(rst_n), .m1_req(m1_req), .m2_req(m2_req), .bus_s_ack(bus_s_ack),
        .m1_grant(b_m1_grant), .m2_grant(b_m2_grant), .msel(b_msel),
        .arb_timeout(b_arb_timeout), .arb_busy(b_arb_busy)
    );

    // Output vector order: {m1_grant, m2_grant, msel, arb_timeout, arb_busy}
    typedef struct {
        string      name;
        logic       m1;
        logic       m2;
        logic       ack;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [4:0] outs8();
        return {m1_grant, m2_grant, msel, arb_timeout, arb_busy};
    endfunction

    function automatic logic [4:0] outs64();
        return {b_m1_grant, b_m2_grant, b_msel, b_arb_timeout, b_arb_busy};
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {g1,g2,msel,to,busy}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m1, input logic m2, input logic ack);
        m1_req    = m1;
        m2_req    = m2;
        bus_s_ack = ack;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Contention twice, ended by ack.
        vecs[0]  = '{"cont1_grant",   1, 1, 0, 5'b10001};
        vecs[1]  = '{"cont1_ack",     1, 1, 1, 5'b00000};
        vecs[2]  = '{"cont1_idle",    1, 1, 0, 5'b00000};
        vecs[3]  = '{"cont2_grant",   1, 1, 0, RR ? 5'b01101 : 5'b10001};
        vecs[4]  = '{"cont2_ack",     1, 1, 1, RR ? 5'b00100 : 5'b00000};
        vecs[5]  = '{"cont2_idle",    0, 0, 0, RR ? 5'b00100 : 5'b00000};
        // Pending m2 request during an m1 grant.
        vecs[6]  = '{"pend_g1",       1, 0, 0, 5'b10001};
        vecs[7]  = '{"pend_m2_wait1", 1, 1, 0, 5'b10001};
        vecs[8]  = '{"pend_m2_wait2", 1, 1, 0, 5'b10001};
        vecs[9]  = '{"pend_ack",      1, 1, 1, 5'b00000};
        vecs[10] = '{"pend_idle",     0, 1, 0, 5'b00000};
        vecs[11] = '{"pend_g2",       0, 1, 0, 5'b01101};
        // Owner drops request; msel holds through RELEASE and IDLE.
        vecs[12] = '{"drop_release",  0, 0, 0, 5'b00100};
        vecs[13] = '{"drop_idle",     0, 0, 0, 5'b00100};
        vecs[14] = '{"idle_msel_hold",0, 0, 0, 5'b00100};
        // Ack together with request drop: one release only.
        vecs[15] = '{"ackdrop_g1",    1, 0, 0, 5'b10001};
        vecs[16] = '{"ackdrop_rel",   0, 0, 1, 5'b00000};
        vecs[17] = '{"ackdrop_idle",  0, 0, 0, 5'b00000};
        vecs[18] = '{"ackdrop_idle2", 0, 0, 0, 5'b00000};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_state_t8", outs8(), 5'b00000);
        check("reset_state_t64", outs64(), 5'b00000);
        rst_n = 1'b1;

        // Single master on the default-timeout instance, ack in the 30th grant cycle.
        drive(1'b1, 1'b0, 1'b0);
        step();
        check("single_grant", outs64(), 5'b10001);
        for (int i = 2; i <= 30; i++) begin
            if (i == 30) bus_s_ack = 1'b1;
            step();
            check(i == 30 ? "single_ack_release" : "single_hold", outs64(),
                  i == 30 ? 5'b00000 : 5'b10001);
        end
        drive(1'b0, 1'b0, 1'b0);
        step();
        check("single_no_timeout", outs64(), 5'b00000);

        do_reset();
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].m1, vecs[i].m2, vecs[i].ack);
            step();
            check(vecs[i].name, outs8(), vecs[i].exp);
        end

        // Watchdog: grant held for exactly 8 cycles, then a single timeout pulse.
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step();
            check("wd_grant_cycle", outs8(), 5'b10001);
        end
        step();
        check("wd_timeout_pulse", outs8(), 5'b00010);
        step();
        check("wd_pulse_end", outs8(), 5'b00000);
        step();
        check("wd_regrant", outs8(), 5'b10001);

        // Ack arriving on the expiry cycle wins: no timeout pulse.
        for (int i = 1; i <= 7; i++) begin
            step();
            check("ackexp_hold", outs8(), 5'b10001);
        end
        bus_s_ack = 1'b1;
        step();
        check("ackexp_release", outs8(), 5'b00000);
        drive(1'b0, 1'b0, 1'b0);
        step();
        check("ackexp_idle", outs8(), 5'b00000);

        // Reset in the middle of a master 2 grant.
        drive(1'b0, 1'b1, 1'b0);
        step();
        check("rst_g2", outs8(), 5'b01101);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_t8", outs8(), 5'b00000);
        check("rst_async_t64", outs64(), 5'b00000);
        drive(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_first_contention", outs8(), 5'b10001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
